fft_bsram_loader: RTL and testbench

//  Writer side of the fft0/fft1 BSRAM pair used by fft1024. It accepts one
//  1024-sample complex frame on a valid/ready stream and writes it into the two

---
 rtl/fft_bsram_loader.sv | 211 +++++++++++++++++++++
 tb/tb_fft_bsram_loader.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fft_bsram_loader.sv
// Writer side of the fft0/fft1 BSRAM pair: streams one 2*N_HALF-sample complex frame
// into the two banks, then hands the RAMs to fft1024 and waits for its finish.
module fft_bsram_loader #(
    parameter int N_HALF      = 512,
    parameter int ADDR_W      = 11,
    parameter bit BIT_REVERSE = 1'b0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [15:0]       in_re,
    input  logic [15:0]       in_im,
    input  logic              in_last,
    output logic              ce0,
    output logic              oce0,
    output logic              wre0,
    output logic [ADDR_W-1:0] ad0,
    output logic [31:0]       din0,
    output logic              ce1,
    output logic              oce1,
    output logic              wre1,
    output logic [ADDR_W-1:0] ad1,
    output logic [31:0]       din1,
    output logic              sel,
    output logic              fft_start,
    input  logic              fft_finish,
    output logic              frame_done,
    output logic              busy,
    output logic              err_len
);

    localparam int CNT_W = $clog2(2 * N_HALF);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(2 * N_HALF - 1);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LOAD = 3'd1,
        S_KICK = 3'd2,
        S_RUN  = 3'd3,
        S_DONE = 3'd4
    } state_t;

    function automatic logic [CNT_W-1:0] bitrev(input logic [CNT_W-1:0] v);
        logic [CNT_W-1:0] r;
        r = {CNT_W{1'b0}};
        for (int i = 0; i < CNT_W; i++) begin
            r[i] = v[CNT_W-1-i];
        end
        return r;
    endfunction

    state_t           state_r, state_nxt_s;
    logic             last_r, last_nxt_s;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] idx_s;
    logic             xfer_s;
    logic             final_s;

    logic             in_ready_r, in_ready_nxt_s;
    logic             sel_r, sel_nxt_s;
    logic             fft_start_r, fft_start_nxt_s;
    logic             frame_done_r, frame_done_nxt_s;
    logic             busy_r, busy_nxt_s;
    logic             err_len_r;
    logic             ce0_r, wre0_r, ce1_r, wre1_r;
    logic [ADDR_W-1:0] ad0_r, ad1_r;
    logic [31:0]      din0_r, din1_r;

    // State register; last_r marks the cycle in which the final write is being issued
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= S_IDLE;
            last_r  <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            last_r  <= last_nxt_s;
        end
    end

    // Next-state logic and transfer decode
    always_comb begin
        state_nxt_s = state_r;
        last_nxt_s  = 1'b0;
        xfer_s      = (state_r == S_LOAD) && in_valid && in_ready_r;
        final_s     = xfer_s && (cnt_r == CNT_MAX);
        case (state_r)
            S_IDLE: begin
                if (load_start) begin
                    state_nxt_s = S_LOAD;
                end else begin
                    state_nxt_s = S_IDLE;
                end
            end
            S_LOAD: begin
                if (last_r) begin
                    state_nxt_s = S_KICK;
                end else begin
                    state_nxt_s = S_LOAD;
                    last_nxt_s  = final_s;
                end
            end
            S_KICK:  state_nxt_s = S_RUN;
            S_RUN: begin
                if (fft_finish) begin
                    state_nxt_s = S_DONE;
                end else begin
                    state_nxt_s = S_RUN;
                end
            end
            S_DONE:  state_nxt_s = S_IDLE;
            default: state_nxt_s = S_IDLE;
        endcase
    end

    // Control outputs decoded from the next state so the registered copies line up with it
    always_comb begin
        in_ready_nxt_s   = (state_nxt_s == S_LOAD) && !last_nxt_s;
        fft_start_nxt_s  = (state_nxt_s == S_KICK);
        sel_nxt_s        = (state_nxt_s == S_KICK) || (state_nxt_s == S_RUN);
        frame_done_nxt_s = (state_nxt_s == S_DONE);
        busy_nxt_s       = (state_nxt_s != S_IDLE);
        if (BIT_REVERSE) begin
            idx_s = bitrev(cnt_r);
        end else begin
            idx_s = cnt_r;
        end
    end

    // Registered control outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_ready_r   <= 1'b0;
            fft_start_r  <= 1'b0;
            sel_r        <= 1'b0;
            frame_done_r <= 1'b0;
            busy_r       <= 1'b0;
        end else begin
            in_ready_r   <= in_ready_nxt_s;
            fft_start_r  <= fft_start_nxt_s;
            sel_r        <= sel_nxt_s;
            frame_done_r <= frame_done_nxt_s;
            busy_r       <= busy_nxt_s;
        end
    end

    // Sample counter, length error flag and BSRAM write port; idle bank keeps ad/din
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r     <= {CNT_W{1'b0}};
            err_len_r <= 1'b0;
            ce0_r     <= 1'b0;
            wre0_r    <= 1'b0;
            ad0_r     <= {ADDR_W{1'b0}};
            din0_r    <= 32'd0;
            ce1_r     <= 1'b0;
            wre1_r    <= 1'b0;
            ad1_r     <= {ADDR_W{1'b0}};
            din1_r    <= 32'd0;
        end else begin
            ce0_r  <= 1'b0;
            wre0_r <= 1'b0;
            ce1_r  <= 1'b0;
            wre1_r <= 1'b0;
            if ((state_r == S_IDLE) && load_start) begin
                cnt_r     <= {CNT_W{1'b0}};
                err_len_r <= 1'b0;
            end else if (xfer_s) begin
                cnt_r <= cnt_r + CNT_W'(1);
                if (in_last != (cnt_r == CNT_MAX)) begin
                    err_len_r <= 1'b1;
                end else begin
                    err_len_r <= err_len_r;
                end
                if (!idx_s[CNT_W-1]) begin
                    ce0_r  <= 1'b1;
                    wre0_r <= 1'b1;
                    ad0_r  <= {{(ADDR_W-CNT_W+1){1'b0}}, idx_s[CNT_W-2:0]};
                    din0_r <= {in_re, in_im};
                end else begin
                    ce1_r  <= 1'b1;
                    wre1_r <= 1'b1;
                    ad1_r  <= {{(ADDR_W-CNT_W+1){1'b0}}, idx_s[CNT_W-2:0]};
                    din1_r <= {in_re, in_im};
                end
            end else begin
                cnt_r     <= cnt_r;
                err_len_r <= err_len_r;
            end
        end
    end

    assign in_ready   = in_ready_r;
    assign ce0        = ce0_r;
    assign oce0       = 1'b0;
    assign wre0       = wre0_r;
    assign ad0        = ad0_r;
    assign din0       = din0_r;
    assign ce1        = ce1_r;
    assign oce1       = 1'b0;
    assign wre1       = wre1_r;
    assign ad1        = ad1_r;
    assign din1       = din1_r;
    assign sel        = sel_r;
    assign fft_start  = fft_start_r;
    assign frame_done = frame_done_r;
    assign busy       = busy_r;
    assign err_len    = err_len_r;

endmodule

// File: tb/tb_fft_bsram_loader.sv
// Scoreboard bench for fft_bsram_loader: one instance in natural order, one in
// bit-reversed order, both fed the same randomized frames.
module tb_fft_bsram_loader;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        load_start = 1'b0;
    logic        in_valid = 1'b0;
    logic [15:0] in_re = 16'd0;
    logic [15:0] in_im = 16'd0;
    logic        in_last = 1'b0;
    logic        fft_finish = 1'b0;

    logic        in_ready_a, ce0_a, oce0_a, wre0_a, ce1_a, oce1_a, wre1_a;
    logic        sel_a, fft_start_a, frame_done_a, busy_a, err_len_a;
    logic [10:0] ad0_a, ad1_a;
    logic [31:0] din0_a, din1_a;
    logic        in_ready_b, ce0_b, oce0_b, wre0_b, ce1_b, oce1_b, wre1_b;
    logic        sel_b, fft_start_b, frame_done_b, busy_b, err_len_b;
    logic [10:0] ad0_b, ad1_b;
    logic [31:0] din0_b, din1_b;

    fft_bsram_loader #(.N_HALF(512), .ADDR_W(11), .BIT_REVERSE(1'b0)) dut_a (
        .clk(clk), .rst_n(rst_n), .load_start(load_start), .in_valid(in_valid),
        .in_ready(in_ready_a), .in_re(in_re), .in_im(in_im), .in_last(in_last),
        .ce0(ce0_a), .oce0(oce0_a), .wre0(wre0_a), .ad0(ad0_a), .din0(din0_a),
        .ce1(ce1_a), .oce1(oce1_a), .wre1(wre1_a), .ad1(ad1_a), .din1(din1_a),
        .sel(sel_a), .fft_start(fft_start_a), .fft_finish(fft_finish),
        .frame_done(frame_done_a), .busy(busy_a), .err_len(err_len_a));

    fft_bsram_loader #(.N_HALF(512), .ADDR_W(11), .BIT_REVERSE(1'b1)) dut_b (
        .clk(clk), .rst_n(rst_n), .load_start(load_start), .in_valid(in_valid),
        .in_ready(in_ready_b), .in_re(in_re), .in_im(in_im), .in_last(in_last),
        .ce0(ce0_b), .oce0(oce0_b), .wre0(wre0_b), .ad0(ad0_b), .din0(din0_b),
        .ce1(ce1_b), .oce1(oce1_b), .wre1(wre1_b), .ad1(ad1_b), .din1(din1_b),
        .sel(sel_b), .fft_start(fft_start_b), .fft_finish(fft_finish),
        .frame_done(frame_done_b), .busy(busy_b), .err_len(err_len_b));

    always #5 clk = ~clk;

    typedef struct packed {
        logic        bank;
        logic [10:0] ad;
        logic [31:0] d;
    } wr_t;

    wr_t         exp_q[2][$];
    logic [31:0] ram[2][2][512];
    int          wr_cnt[2];
    int          start_cnt = 0;
    int          checks = 0;
    int          failures = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int brev10(input int n);
        int r = 0;
        for (int i = 0; i < 10; i++) begin
            if (((n >> i) & 1) != 0) r |= (1 << (9 - i));
        end
        return r;
    endfunction

    // Expected BSRAM write for sample n of the frame, for both orderings
    task automatic push_exp(input int n, input logic [15:0] re, input logic [15:0] im);
        for (int d = 0; d < 2; d++) begin
            int  idx;
            wr_t e;
            idx    = (d == 1) ? brev10(n) : n;
            e.bank = (idx >= 512);
            e.ad   = 11'(idx % 512);
            e.d    = {re, im};
            exp_q[d].push_back(e);
        end
    endtask

    task automatic mon(input int d, input logic c0, input logic w0, input logic [10:0] a0,
                       input logic [31:0] x0, input logic c1, input logic w1,
                       input logic [10:0] a1, input logic [31:0] x1);
        wr_t e;
        logic b;
        if (c0 && w0 && c1 && w1) begin
            chk("both_banks_written", 32'd1, 32'd0);
        end else if ((c0 && w0) || (c1 && w1)) begin
            b = c1 && w1;
            wr_cnt[d]++;
            ram[d][b][b ? a1[8:0] : a0[8:0]] = b ? x1 : x0;
            if (exp_q[d].size() == 0) begin
                chk("unexpected_write", 32'd1, 32'd0);
            end else begin
                e = exp_q[d].pop_front();
                chk("wr_bank", {31'd0, b}, {31'd0, e.bank});
                chk("wr_addr", {21'd0, b ? a1 : a0}, {21'd0, e.ad});
                chk("wr_data", b ? x1 : x0, e.d);
            end
        end
    endtask

    // Monitor: pops the scoreboard whenever either DUT issues a BSRAM write
    always @(negedge clk) begin
        if (rst_n) begin
            if (fft_start_a) start_cnt++;
            mon(0, ce0_a, wre0_a, ad0_a, din0_a, ce1_a, wre1_a, ad1_a, din1_a);
            mon(1, ce0_b, wre0_b, ad0_b, din0_b, ce1_b, wre1_b, ad1_b, din1_b);
        end
    end

    // vmode: 0 always valid, 1 valid one cycle in three, 2 random ~60%
    // pat: 0 re=n im=-n, 1 random data; last_at<0 means in_last on sample 1023 only
    task automatic run_frame(input int pat, input int vmode, input int last_at,
                             input int fin_dly, input bit kick_fin, input int abort_at);
        int   n = 0;
        int   cyc = 0;
        int   wr0 = wr_cnt[0];
        int   wr1 = wr_cnt[1];
        int   st0 = start_cnt;
        int   bad_sel = 0;
        logic v;
        logic [15:0] re, im;
        @(negedge clk);
        load_start = 1'b1;
        @(negedge clk);
        load_start = 1'b0;
        chk("ready_up", {31'd0, in_ready_a}, 32'd1);
        chk("err_cleared", {31'd0, err_len_a}, 32'd0);
        while (n < 1024 && cyc < 20000) begin
            if (n == abort_at) begin
                rst_n    = 1'b0;
                in_valid = 1'b0;
                #1;
                chk("rst_ready", {31'd0, in_ready_a}, 32'd0);
                chk("rst_busy", {31'd0, busy_a}, 32'd0);
                chk("rst_ad0", {21'd0, ad0_a}, 32'd0);
                chk("rst_din0", din0_a, 32'd0);
                chk("rst_ce0", {31'd0, ce0_a}, 32'd0);
                exp_q[0].delete();
                exp_q[1].delete();
                @(negedge clk);
                rst_n = 1'b1;
                @(negedge clk);
                return;
            end
            case (vmode)
                0:       v = 1'b1;
                1:       v = (cyc % 3 == 0);
                default: v = ($urandom_range(99) < 60);
            endcase
            if (pat == 0) begin
                re = 16'(n);
                im = 16'(-n);
            end else begin
                re = 16'($urandom);
                im = 16'($urandom);
            end
            in_valid   = v;
            in_re      = re;
            in_im      = im;
            in_last    = (last_at < 0) ? (n == 1023) : (n == last_at);
            load_start = (cyc == 40);
            if (v && in_ready_a) begin
                push_exp(n, re, im);
                n++;
            end
            @(negedge clk);
            cyc++;
        end
        load_start = 1'b0;
        chk("frame_accepted_1024", 32'(n), 32'd1024);
        in_valid = 1'b1;
        chk("ready_drop", {31'd0, in_ready_a}, 32'd0);
        chk("ready_drop_br", {31'd0, in_ready_b}, 32'd0);
        chk("start_not_early", {31'd0, fft_start_a}, 32'd0);
        @(negedge clk);
        in_valid   = 1'b0;
        in_last    = 1'b0;
        chk("fft_start", {31'd0, fft_start_a}, 32'd1);
        chk("sel_kick", {31'd0, sel_a}, 32'd1);
        chk("ce_kick", {31'd0, ce0_a | ce1_a}, 32'd0);
        fft_finish = kick_fin;
        for (int i = 0; i < fin_dly; i++) begin
            @(negedge clk);
            fft_finish = 1'b0;
            if (!sel_a || fft_start_a || frame_done_a || !busy_a) bad_sel++;
        end
        fft_finish = 1'b1;
        @(negedge clk);
        fft_finish = 1'b0;
        chk("run_sel_held", 32'(bad_sel), 32'd0);
        chk("frame_done", {31'd0, frame_done_a}, 32'd1);
        chk("sel_dropped", {31'd0, sel_a}, 32'd0);
        chk("busy_done", {31'd0, busy_a}, 32'd1);
        @(negedge clk);
        chk("frame_done_pulse", {31'd0, frame_done_a}, 32'd0);
        chk("busy_idle", {31'd0, busy_a}, 32'd0);
        chk("err_len", {31'd0, err_len_a},
            {31'd0, (last_at >= 0 && last_at != 1023)});
        chk("wre_count", 32'(wr_cnt[0] - wr0), 32'd1024);
        chk("wre_count_br", 32'(wr_cnt[1] - wr1), 32'd1024);
        chk("start_once", 32'(start_cnt - st0), 32'd1);
        chk("queue_empty", 32'(exp_q[0].size() + exp_q[1].size()), 32'd0);
    endtask

    initial begin
        int bad;
        wr_cnt[0] = 0;
        wr_cnt[1] = 0;
        repeat (3) @(negedge clk);
        chk("reset_ready", {31'd0, in_ready_a}, 32'd0);
        chk("reset_sel", {31'd0, sel_a | sel_b}, 32'd0);
        chk("reset_ctrl", {28'd0, ce0_a, wre0_a, ce1_a, wre1_a}, 32'd0);
        chk("reset_oce", {30'd0, oce0_a, oce1_a}, 32'd0);
        chk("reset_ad1", {21'd0, ad1_a}, 32'd0);
        chk("reset_din1", din1_a, 32'd0);
        chk("reset_flags", {28'd0, busy_a, fft_start_a, frame_done_a, err_len_a}, 32'd0);
        rst_n = 1'b1;

        // natural order ramp, continuous valid
        run_frame(0, 0, -1, 5, 1'b0, -1);
        chk("t1_fft0_5", ram[0][0][5], 32'h0005FFFB);
        chk("t1_fft1_0", ram[0][1][0], 32'h0200FE00);
        chk("t6_br_s1", ram[1][1][0], 32'h0001FFFF);
        chk("t6_br_s2", ram[1][0][256], 32'h0002FFFE);

        // sparse valid, same image
        run_frame(0, 1, -1, 3, 1'b0, -1);
        bad = 0;
        for (int n = 0; n < 1024; n++) begin
            if (ram[0][n / 512][n % 512] !== {16'(n), 16'(-n)}) bad++;
        end
        chk("t2_image", 32'(bad), 32'd0);

        // early in_last, random data
        run_frame(1, 2, 100, 4, 1'b0, -1);
        // long RUN with finish also raised during KICK
        run_frame(1, 0, -1, 50, 1'b1, -1);
        // reset mid-frame, then a fresh frame
        run_frame(1, 2, -1, 0, 1'b0, 300);
        run_frame(0, 2, -1, 2, 1'b0, -1);
        chk("t5_first_write", ram[0][0][0], 32'h00000000);
        // missing in_last, then a clean back-to-back frame
        run_frame(1, 2, 5000, 1, 1'b0, -1);
        run_frame(1, 0, -1, 1, 1'b0, -1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
